// File: rtl/spi_flash_rdid_responder.sv
// SPI flash RDID responder: captures one command byte per frame and, for
// RDID (8'h9F), streams back the 24-bit JEDEC ID MSB first. A run of
// SPICLK-low cycles ends a frame; shorter low runs only stall the transfer.
//
// state  | meaning
// IDLE   | between frames, waiting for the first command bit
// CMD    | shifting in the remaining command bits
// RESP   | streaming the JEDEC ID on SPIMISO
// IGNORE | rest of frame discarded until the frame gap is seen
module spi_flash_rdid_responder #(
  parameter logic [7:0]  MFG_ID    = 8'h20,
  parameter logic [7:0]  MEM_TYPE  = 8'h20,
  parameter logic [7:0]  MEM_CAP   = 8'h16,
  parameter int unsigned FRAME_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  output logic       SPIMISO,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       rdid_done
);

  typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

  localparam logic [3:0] GAP_LIM  = 4'(FRAME_GAP);
  localparam logic [7:0] CMD_RDID = 8'h9F;

  state_t      state;
  logic [6:0]  cmd_sh;
  logic [3:0]  bit_cnt;
  logic [22:0] resp_sh;
  logic [4:0]  resp_left;
  logic [3:0]  gap_cnt;

  logic [7:0]  cmd_next;
  logic        gap_hit;

  // The bit arriving on this edge completes the shifted command value.
  assign cmd_next = {cmd_sh, SPIMOSI};

  // A low strobe that brings the gap counter up to the limit ends the frame;
  // the counter never exceeds the limit, so the 4-bit sum cannot wrap.
  assign gap_hit = !SPICLK && ((gap_cnt + 4'd1) >= GAP_LIM);

  // Frame sequencer with registered SPIMISO and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_sh    <= '0;
      bit_cnt   <= '0;
      resp_sh   <= '0;
      resp_left <= '0;
      gap_cnt   <= '0;
      SPIMISO   <= 1'b0;
      cmd_valid <= 1'b0;
      rdid_done <= 1'b0;
      cmd_byte  <= 8'h00;
    end else begin
      cmd_valid <= 1'b0;
      rdid_done <= 1'b0;

      if (state == IDLE || SPICLK || gap_hit) begin
        gap_cnt <= '0;
      end else if (gap_cnt != 4'hF) begin
        gap_cnt <= gap_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          SPIMISO <= 1'b0;
          bit_cnt <= '0;
          if (SPICLK) begin
            cmd_sh  <= {6'b0, SPIMOSI};
            bit_cnt <= 4'd1;
            state   <= CMD;
          end
        end

        CMD: begin
          if (SPICLK) begin
            if (bit_cnt == 4'd7) begin
              cmd_byte  <= cmd_next;
              cmd_valid <= 1'b1;
              bit_cnt   <= '0;
              if (cmd_next == CMD_RDID) begin
                // First ID bit goes out right away so the master sees it
                // on its very next strobe.
                SPIMISO   <= MFG_ID[7];
                resp_sh   <= {MFG_ID[6:0], MEM_TYPE, MEM_CAP};
                resp_left <= 5'd23;
                state     <= RESP;
              end else begin
                state <= IGNORE;
              end
            end else begin
              cmd_sh  <= cmd_next[6:0];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (gap_hit) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end

        RESP: begin
          if (SPICLK) begin
            if (resp_left == 5'd0) begin
              SPIMISO   <= 1'b0;
              rdid_done <= 1'b1;
              state     <= IGNORE;
            end else begin
              SPIMISO   <= resp_sh[22];
              resp_sh   <= {resp_sh[21:0], 1'b0};
              resp_left <= resp_left - 5'd1;
            end
          end else if (gap_hit) begin
            SPIMISO <= 1'b0;
            state   <= IDLE;
          end
        end

        IGNORE: begin
          SPIMISO <= 1'b0;
          if (gap_hit) begin
            state <= IDLE;
          end
        end

        default: begin
          SPIMISO <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rdid_responder.sv
// Testbench for spi_flash_rdid_responder: directed and randomized frames
// checked against a frame-level model of the expected SPIMISO stream.
module tb_spi_flash_rdid_responder;

  localparam int FG = 4;
  localparam logic [23:0] JEDEC_ID = 24'h202016;

  logic       clk = 1'b0;
  logic       reset;
  logic       SPICLK;
  logic       SPIMOSI;
  logic       SPIMISO;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       rdid_done;

  int checks = 0;
  int errors = 0;

  logic mon_en = 1'b0;
  logic miso_q[$];
  int   n_cv, n_rd, n_both;
  logic [7:0] last_cv;

  spi_flash_rdid_responder #(
    .MFG_ID(8'h20), .MEM_TYPE(8'h20), .MEM_CAP(8'h16), .FRAME_GAP(FG)
  ) dut (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
    .SPIMISO(SPIMISO), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .rdid_done(rdid_done)
  );

  always #5 clk = ~clk;

  // Observe between edges: bits consumed by the master and the pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (SPICLK) miso_q.push_back(SPIMISO);
      if (cmd_valid) begin n_cv++; last_cv = cmd_byte; end
      if (rdid_done) n_rd++;
      if (cmd_valid && rdid_done) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic sclk, input logic mosi);
    SPICLK  = sclk;
    SPIMOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected bit seen by the master on its k-th strobe of a frame.
  function automatic logic exp_bit(input int k, input logic [7:0] cmd);
    logic [23:0] id;
    id = JEDEC_ID;
    if (k < 8) return 1'b0;
    if (cmd == 8'h9F && (k - 8) < 24) return id[23 - (k - 8)];
    return 1'b0;
  endfunction

  task automatic frame(input string tag, input logic [7:0] cmd, input int nresp,
                       input int st_cmd, input int st_resp, input int st_len);
    int hold_bad;
    int bad;
    logic m;
    hold_bad = 0;
    bad = 0;
    miso_q.delete();
    n_cv = 0;
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == st_cmd) begin
        m = SPIMISO;
        repeat (st_len) begin clk_bit(1'b0, rnd_bit()); if (SPIMISO !== m) hold_bad++; end
      end
      clk_bit(1'b1, cmd[7-i]);
    end
    for (int i = 0; i < nresp; i++) begin
      if (i == st_resp) begin
        m = SPIMISO;
        repeat (st_len) begin clk_bit(1'b0, rnd_bit()); if (SPIMISO !== m) hold_bad++; end
      end
      clk_bit(1'b1, rnd_bit());
    end
    repeat (FG + 2) clk_bit(1'b0, rnd_bit());
    for (int k = 0; k < miso_q.size(); k++)
      if (miso_q[k] !== exp_bit(k, cmd)) bad++;
    chk({tag, "_cv_count"}, n_cv, 1);
    chk({tag, "_cmd_byte"}, last_cv, cmd);
    chk({tag, "_rd_count"}, n_rd, (cmd == 8'h9F && nresp >= 24) ? 1 : 0);
    chk({tag, "_stream_len"}, miso_q.size(), 8 + nresp);
    chk({tag, "_stream_bad"}, bad, 0);
    chk({tag, "_stall_hold"}, hold_bad, 0);
    chk({tag, "_miso_end"}, SPIMISO, 0);
  endtask

  initial begin
    logic [7:0] c;
    int nr, sc, sr, sl;
    reset   = 1'b1;
    SPICLK  = 1'b0;
    SPIMOSI = 1'b0;

    // Reset held five cycles with the strobe toggling underneath.
    repeat (5) begin
      clk_bit(rnd_bit(), rnd_bit());
      chk("reset_outputs", {SPIMISO, cmd_valid, rdid_done, cmd_byte}, 0);
    end
    reset = 1'b0;
    mon_en = 1'b1;
    clk_bit(1'b0, 1'b0);

    frame("rdid", 8'h9F, 24, -1, -1, 0);
    frame("rdid_extra", 8'h9F, 30, -1, -1, 0);
    frame("other05", 8'h05, 24, -1, -1, 0);

    // Partial command cut by a full-length gap leaves cmd_byte alone.
    n_cv = 0;
    repeat (5) clk_bit(1'b1, rnd_bit());
    repeat (FG) clk_bit(1'b0, rnd_bit());
    chk("partial_no_cv", n_cv, 0);
    chk("partial_cmd_hold", cmd_byte, 8'h05);
    frame("after_partial", 8'h9F, 24, -1, -1, 0);

    frame("stall2", 8'h9F, 24, 4, 11, 2);
    frame("stall_max", 8'h9F, 24, 7, 0, FG - 1);

    // Reset landing on a strobe after the 10th response bit.
    miso_q.delete();
    n_rd = 0;
    for (int i = 0; i < 8; i++) clk_bit(1'b1, c_bit(i));
    repeat (10) clk_bit(1'b1, rnd_bit());
    reset = 1'b1;
    clk_bit(1'b1, rnd_bit());
    reset = 1'b0;
    chk("rst_mid_outputs", {SPIMISO, cmd_valid, rdid_done, cmd_byte}, 0);
    repeat (3) clk_bit(1'b0, 1'b0);
    chk("rst_mid_no_rd", n_rd, 0);
    chk("rst_mid_miso", SPIMISO, 0);
    frame("after_reset", 8'h9F, 24, -1, -1, 0);

    // Randomized frames: mix of RDID and arbitrary commands with stalls.
    for (int f = 0; f < 10; f++) begin
      c  = ($urandom_range(0, 1) == 1) ? 8'h9F : 8'($urandom_range(0, 255));
      nr = $urandom_range(20, 30);
      sc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
      sr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nr - 1) : -1;
      sl = $urandom_range(1, FG - 1);
      frame("rand", c, nr, sc, sr, sl);
    end

    chk("never_both", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic c_bit(input int i);
    logic [7:0] v;
    v = 8'h9F;
    return v[7-i];
  endfunction

endmodule

// File: doc/spi_flash_rdid_responder.md
SPI_FLASH_RDID_RESPONDER -- requirements
Module: spi_flash_rdid_responder

Interface
REQ-001 Parameter MFG_ID, 8'h20, JEDEC manufacturer byte returned first.
REQ-002 Parameter MEM_TYPE, 8'h20, memory-type byte returned second.
REQ-003 Parameter MEM_CAP, 8'h16, capacity byte returned third.
REQ-004 Parameter FRAME_GAP, 4, consecutive SPICLK-low clk cycles that end a frame; legal range 2..15.
REQ-005 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 SPICLK  input  1  bit strobe from the SPI master, synchronous to clk; a clk edge with SPICLK=1 is one bit time.
REQ-008 SPIMOSI  input  1  command bit from the master, MSB first.
REQ-009 SPIMISO  output  1  response bit to the master, MSB first, registered.
REQ-010 cmd_valid  output  1  one-cycle pulse when a complete command byte is captured.
REQ-011 cmd_byte  output  8  last captured command byte; held until the next capture.
REQ-012 rdid_done  output  1  one-cycle pulse when the 24th RDID response bit is consumed.

Function
REQ-013 The block SHALL implement states IDLE, CMD, RESP, IGNORE.
REQ-014 IDLE: SPIMISO=0; on a SPICLK=1 edge, shift SPIMOSI into the command register, set bit_cnt=1, go to CMD.
REQ-015 CMD: each SPICLK=1 edge SHALL shift SPIMOSI in (MSB first) and increment bit_cnt.
REQ-016 On the edge sampling the 8th bit, cmd_byte SHALL update and cmd_valid SHALL assert in the following cycle for exactly one cycle.
REQ-017 If the captured byte equals 8'h9F, the FSM SHALL go to RESP and load the 24-bit response {MFG_ID, MEM_TYPE, MEM_CAP}; otherwise it SHALL go to IGNORE.
REQ-018 RESP: SPIMISO SHALL present response bit 23 in the cycle after the 8th command bit is sampled (zero added latency).
REQ-019 RESP: each SPICLK=1 edge SHALL advance SPIMISO to the next lower response bit; SPIMISO SHALL hold while SPICLK=0.
REQ-020 On the edge consuming bit 0, rdid_done SHALL pulse for one cycle in the following cycle, SPIMISO SHALL go 0, and the FSM SHALL go to IGNORE.
REQ-021 IGNORE: SPIMISO=0; SPIMOSI is discarded; SPICLK=1 edges have no effect beyond resetting the gap counter.
REQ-022 A gap counter SHALL clear on any SPICLK=1 edge and increment, saturating, on SPICLK=0 edges in CMD, RESP and IGNORE.
REQ-023 When the gap counter reaches FRAME_GAP, the FSM SHALL return to IDLE in the next cycle, SPIMISO=0, bit_cnt=0.
REQ-024 A gap in CMD SHALL discard the partial command: no cmd_valid, cmd_byte unchanged.
REQ-025 A gap in RESP SHALL abort the response: no rdid_done; the next frame starts with a fresh command.
REQ-026 SPICLK low runs shorter than FRAME_GAP SHALL stall, not abort, CMD and RESP.
REQ-027 cmd_valid and rdid_done SHALL never assert in the same cycle.

Reset
REQ-028 With reset=1 at a clk edge: state=IDLE, SPIMISO=0, cmd_valid=0, rdid_done=0, cmd_byte=8'h00, bit_cnt=0, gap counter=0.
REQ-029 Reset SHALL take priority over SPICLK in the same cycle, including mid-CMD or mid-RESP, with no pulse emitted.

Verification
REQ-030 Hold reset for 5 cycles -> all outputs 0 and cmd_byte=8'h00.
REQ-031 Send 0x9F, 8 consecutive SPICLK cycles, then 24 more -> cmd_valid pulses once with cmd_byte=8'h9F; SPIMISO stream equals 0x202016 MSB first; rdid_done pulses once; SPIMISO=0 afterwards.
REQ-032 Send 0x05, then 24 SPICLK cycles -> cmd_valid with cmd_byte=8'h05; SPIMISO=0 throughout; no rdid_done.
REQ-033 Send 5 bits, hold SPICLK low for 4 cycles, then send 0x9F -> no cmd_valid for the partial byte; the full RDID response is correct.
REQ-034 Send 0x9F with SPICLK low for 2 cycles mid-command and mid-response -> response is still 0x202016 with SPIMISO held during the stalls.
REQ-035 Assert reset after the 10th response bit -> next cycle SPIMISO=0 and state IDLE; no rdid_done; a following 0x9F frame is served correctly.
